// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ
// requesters, with a single-entry registered response slot and an
// accepted-operation counter.
module alu_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [32*NREQ-1:0]    req_a,
  input  logic [32*NREQ-1:0]    req_b,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [3*NREQ-1:0]     req_br_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_op,
  output logic [2:0]            alu_br_ctrl,
  input  logic [31:0]           alu_c,
  input  logic                  alu_br_true,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [31:0]           rsp_c,
  output logic                  rsp_br_true,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic       found;
  logic       can_accept;
  logic       grant;
  int         idx;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
  end

  // The slot can take a new result when empty or draining this cycle.
  assign can_accept = (state == EMPTY) || rsp_ready;
  assign grant      = found && can_accept;
  assign req_ready  = grant ? (NREQ'(1) << win) : '0;
  assign rsp_valid  = (state == FULL);

  // Steer the granted requester onto the ALU; idle inputs are zero.
  always_comb begin
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_op      = 3'd0;
    alu_br_ctrl = 3'd0;
    if (grant) begin
      alu_a       = req_a[32*win +: 32];
      alu_b       = req_b[32*win +: 32];
      alu_op      = req_op[3*win +: 3];
      alu_br_ctrl = req_br_ctrl[3*win +: 3];
    end
  end

  // Slot FSM, response capture, rr pointer and op counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      rsp_id      <= 2'd0;
      rsp_c       <= 32'd0;
      rsp_br_true <= 1'b0;
      op_count    <= '0;
      ptr         <= 2'(NREQ - 1);
    end else begin
      if (grant) begin
        state       <= FULL;
        rsp_id      <= win;
        rsp_c       <= alu_c;
        rsp_br_true <= alu_br_true;
        ptr         <= win;
        op_count    <= op_count + CNT_W'(1);
      end else if (state == FULL && rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule
